// File: rtl/conv_stream_feeder_if.sv
// Stream bundle (valid/ready, 16-bit data, byte keep, last) shared by the
// feeder's outbound tap/sample stream and its inbound result stream.
interface conv_stream_feeder_if;
  logic        TVALID;
  logic [15:0] TDATA;
  logic [1:0]  TKEEP;
  logic        TLAST;
  logic        TREADY;

  modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/conv_stream_feeder.sv
// Feeds a convolution engine: streams the filter taps and then the data samples
// from local buffers, and collects result beats while checking the result count.
module conv_stream_feeder #(
  parameter int FILT_DEPTH = 256,
  parameter int DATA_DEPTH = 1024
) (
  input  logic        M_AXIS_ACLK,
  input  logic        M_AXIS_ARESETN,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [9:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [8:0]  filt_len,
  input  logic [15:0] data_len,
  input  logic        start,
  conv_stream_feeder_if.master M_AXIS,
  conv_stream_feeder_if.slave  S_AXIS,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic [31:0] res_count,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        err_cfg
);

  localparam int FAW = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;
  localparam int DAW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [16:0] FDEPTH = 17'(FILT_DEPTH);
  localparam logic [16:0] DDEPTH = 17'(DATA_DEPTH);
  localparam logic [FAW-1:0] FZERO = '0;
  localparam logic [DAW-1:0] DZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILT  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state_r, state_nxt;

  logic [15:0] filt_mem [FILT_DEPTH];
  logic [15:0] data_mem [DATA_DEPTH];

  logic [8:0]  flen_r;
  logic [15:0] dlen_r;
  logic [15:0] idx_r, idx_nxt_s;
  logic [15:0] tdata_r, tdata_nxt_s;
  logic        tlast_r, tlast_nxt_s;
  logic        res_valid_r, done_r, err_len_r, err_cfg_r;
  logic [15:0] res_data_r;
  logic [31:0] res_count_r;

  logic        cfg_ok_s, start_ok_s, start_bad_s;
  logic        tvalid_s, sready_s, m_hs_s, s_hs_s;
  logic        wr_f_s, wr_d_s;
  logic [15:0] idx_inc_s, flen_last_s, dlen_last_s;
  logic [16:0] exp_cnt_s;
  logic        cnt_beat_s, tlast_in_s, len_bad_s;
  logic [31:0] cnt_sat_s, cnt_after_s;

  // Handshakes, length checks and next state / next beat selection.
  always_comb begin
    state_nxt   = state_r;
    idx_nxt_s   = idx_r;
    tdata_nxt_s = tdata_r;
    tlast_nxt_s = tlast_r;

    cfg_ok_s    = ({8'd0, filt_len} >= 17'd1) && ({8'd0, filt_len} <= FDEPTH) &&
                  ({1'b0, data_len} >= 17'd1) && ({1'b0, data_len} <= DDEPTH);
    start_ok_s  = (state_r == IDLE) && start && cfg_ok_s;
    start_bad_s = (state_r == IDLE) && start && !cfg_ok_s;
    tvalid_s    = (state_r == FILT) || (state_r == DATA);
    sready_s    = (state_r == DATA) || (state_r == DRAIN);
    m_hs_s      = tvalid_s && M_AXIS.TREADY;
    s_hs_s      = sready_s && S_AXIS.TVALID;
    wr_f_s      = (state_r == IDLE) && wr_en && !wr_sel && ({7'd0, wr_addr} < FDEPTH);
    wr_d_s      = (state_r == IDLE) && wr_en &&  wr_sel && ({7'd0, wr_addr} < DDEPTH);

    idx_inc_s   = idx_r + 16'd1;
    flen_last_s = {7'd0, flen_r} - 16'd1;
    dlen_last_s = dlen_r - 16'd1;
    // Full 17-bit width: 256 taps + 1024 samples must not wrap.
    exp_cnt_s   = {8'd0, flen_r} + {1'b0, dlen_r} - 17'd1;

    cnt_beat_s  = s_hs_s && (S_AXIS.TKEEP == 2'b11);
    cnt_sat_s   = (res_count_r == 32'hFFFF_FFFF) ? res_count_r : res_count_r + 32'd1;
    cnt_after_s = cnt_beat_s ? cnt_sat_s : res_count_r;
    tlast_in_s  = s_hs_s && S_AXIS.TLAST;
    len_bad_s   = (cnt_after_s != {15'd0, exp_cnt_s});

    case (state_r)
      IDLE:    state_nxt = start_ok_s ? FILT : IDLE;
      FILT:    state_nxt = (m_hs_s && tlast_r) ? DATA : FILT;
      DATA:    state_nxt = (m_hs_s && tlast_r) ? DRAIN : DATA;
      DRAIN:   state_nxt = tlast_in_s ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase

    // The next beat is prefetched into tdata_r/tlast_r so they stay put during stalls.
    if (start_ok_s) begin
      idx_nxt_s   = 16'd0;
      tdata_nxt_s = filt_mem[FZERO];
      tlast_nxt_s = (filt_len == 9'd1);
    end else if (m_hs_s && (state_r == FILT)) begin
      if (tlast_r) begin
        idx_nxt_s   = 16'd0;
        tdata_nxt_s = data_mem[DZERO];
        tlast_nxt_s = (dlen_r == 16'd1);
      end else begin
        idx_nxt_s   = idx_inc_s;
        tdata_nxt_s = filt_mem[idx_inc_s[FAW-1:0]];
        tlast_nxt_s = (idx_inc_s == flen_last_s);
      end
    end else if (m_hs_s && (state_r == DATA)) begin
      if (tlast_r) begin
        idx_nxt_s   = 16'd0;
        tdata_nxt_s = tdata_r;
        tlast_nxt_s = 1'b0;
      end else begin
        idx_nxt_s   = idx_inc_s;
        tdata_nxt_s = data_mem[idx_inc_s[DAW-1:0]];
        tlast_nxt_s = (idx_inc_s == dlen_last_s);
      end
    end else begin
      idx_nxt_s   = idx_r;
      tdata_nxt_s = tdata_r;
      tlast_nxt_s = tlast_r;
    end
  end

  // Buffer load port; contents deliberately survive (and are not cleared by) reset.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_f_s) begin
      filt_mem[wr_addr[FAW-1:0]] <= wr_data;
    end
    if (wr_d_s) begin
      data_mem[wr_addr[DAW-1:0]] <= wr_data;
    end
  end

  // FSM state register.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Beat pointer, latched lengths, result capture, count and status flags.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      idx_r       <= 16'd0;
      tdata_r     <= 16'd0;
      tlast_r     <= 1'b0;
      flen_r      <= 9'd0;
      dlen_r      <= 16'd0;
      res_valid_r <= 1'b0;
      res_data_r  <= 16'd0;
      res_count_r <= 32'd0;
      done_r      <= 1'b0;
      err_len_r   <= 1'b0;
      err_cfg_r   <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      tdata_r     <= tdata_nxt_s;
      tlast_r     <= tlast_nxt_s;
      res_valid_r <= cnt_beat_s;
      done_r      <= tlast_in_s && (state_r == DRAIN);
      err_cfg_r   <= start_bad_s;
      if (start_ok_s) begin
        flen_r <= filt_len;
        dlen_r <= data_len;
      end
      if (cnt_beat_s) begin
        res_data_r <= S_AXIS.TDATA;
      end
      res_count_r <= start_ok_s ? 32'd0 : cnt_after_s;
      if (start_ok_s) begin
        err_len_r <= 1'b0;
      end else if (tlast_in_s && (state_r == DATA)) begin
        err_len_r <= 1'b1;
      end else if (tlast_in_s && (state_r == DRAIN) && len_bad_s) begin
        err_len_r <= 1'b1;
      end
    end
  end

  assign M_AXIS.TVALID = tvalid_s;
  assign M_AXIS.TDATA  = tdata_r;
  assign M_AXIS.TKEEP  = 2'b11;
  assign M_AXIS.TLAST  = tlast_r;
  assign S_AXIS.TREADY = sready_s;

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_count = res_count_r;
  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign err_len   = err_len_r;
  assign err_cfg   = err_cfg_r;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Bench for conv_stream_feeder: directed and randomized frames checked against
// a reference built from buffer contents, lengths and the result-stream rules.
module tb_conv_stream_feeder;
  localparam int FD = 256;
  localparam int DD = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en, wr_sel, start;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data, data_len;
  logic [8:0]  filt_len;
  logic        res_valid, busy, done, err_len, err_cfg;
  logic [15:0] res_data;
  logic [31:0] res_count;

  conv_stream_feeder_if m_if ();
  conv_stream_feeder_if s_if ();

  conv_stream_feeder #(.FILT_DEPTH(FD), .DATA_DEPTH(DD)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .filt_len(filt_len), .data_len(data_len), .start(start),
    .M_AXIS(m_if), .S_AXIS(s_if),
    .res_valid(res_valid), .res_data(res_data), .res_count(res_count),
    .busy(busy), .done(done), .err_len(err_len), .err_cfg(err_cfg)
  );

  int compared = 0;
  int mismatched = 0;
  logic [15:0] fm [FD];
  logic [15:0] dm [DD];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit sel, input int addr, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 10'(addr); wr_data = d;
    if (!sel && addr < FD) fm[addr] = d;
    if (sel && addr < DD) dm[addr] = d;
  endtask

  task automatic wr_idle();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_small();
    wr(1'b0, 0, 16'd1); wr(1'b0, 1, 16'd2); wr(1'b0, 2, 16'd3);
    for (int i = 0; i < 4; i++) wr(1'b1, i, 16'd1);
    wr_idle();
  endtask

  task automatic load_rand(input int fl, input int dl);
    for (int i = 0; i < fl; i++) wr(1'b0, i, 16'($urandom));
    for (int i = 0; i < dl; i++) wr(1'b1, i, 16'($urandom));
    wr_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(m_if.TVALID), 32'd0);
    check({tag, "_tlast"}, 32'(m_if.TLAST), 32'd0);
    check({tag, "_s_tready"}, 32'(s_if.TREADY), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err_cfg"}, 32'(err_cfg), 32'd0);
    check({tag, "_err_len"}, 32'(err_len), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_res_count"}, res_count, 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
  endtask

  task automatic cfg_err(input int fl, input int dl);
    @(negedge clk);
    filt_len = 9'(fl); data_len = 16'(dl); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", 32'(err_cfg), 32'd1);
    check("cfg_err_busy", 32'(busy), 32'd0);
    check("cfg_err_tvalid", 32'(m_if.TVALID), 32'd0);
    @(negedge clk);
    check("cfg_err_one_cycle", 32'(err_cfg), 32'd0);
    check("cfg_err_still_idle", 32'(busy | m_if.TVALID), 32'd0);
  endtask

  // rmode: 0 = always ready/valid, 1 = TREADY pattern 1,0,0,1, 2 = random
  task automatic run_frame(input int fl, input int dl, input int nres, input int early_idx,
                           input int rmode, input bit rand_keep, input int abort_at,
                           input bit poke_busy);
    logic [15:0] conv [$];
    logic [15:0] rdat [$];
    logic [1:0]  rkeep [$];
    bit          rlast [$];
    logic [15:0] eb [$];
    bit          el [$];
    logic [15:0] expq [$];
    bit pat [4];
    int total, m_ptr, r_ptr, dn_cnt, exp_cnt;
    bit ended, exp_err, prev_stall, ready, sv, fin;
    logic [15:0] prev_td, acc;
    logic prev_tl;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    total = fl + dl; m_ptr = 0; r_ptr = 0; dn_cnt = 0; exp_cnt = 0;
    ended = 1'b0; exp_err = 1'b0; prev_stall = 1'b0; fin = 1'b0;
    prev_td = 16'd0; prev_tl = 1'b0;

    for (int k = 0; k < fl + dl - 1; k++) begin
      acc = 16'd0;
      for (int i = 0; i < fl; i++)
        if (k - i >= 0 && k - i < dl) acc = acc + fm[i] * dm[k - i];
      conv.push_back(acc);
    end
    for (int i = 0; i < fl; i++) begin eb.push_back(fm[i]); el.push_back(i == fl - 1); end
    for (int i = 0; i < dl; i++) begin eb.push_back(dm[i]); el.push_back(i == dl - 1); end
    for (int k = 0; k < nres; k++) begin
      rdat.push_back((k < conv.size()) ? conv[k] : 16'($urandom));
      rkeep.push_back((rand_keep && ($urandom % 4 == 0)) ? 2'($urandom % 3) : 2'b11);
      rlast.push_back((k == nres - 1) || (k == early_idx));
    end

    @(negedge clk);
    filt_len = 9'(fl); data_len = 16'(dl); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_tvalid", 32'(m_if.TVALID), 32'd1);
    check("start_tkeep", 32'(m_if.TKEEP), 32'd3);

    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (poke_busy && cyc == 0) begin
        start = 1'b1; filt_len = 9'd0;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 10'd0; wr_data = ~fm[0];
      end else if (poke_busy && cyc == 1) begin
        start = 1'b0; wr_en = 1'b0; filt_len = 9'(fl);
        check("busy_start_no_err_cfg", 32'(err_cfg), 32'd0);
      end
      if (abort_at > 0 && m_ptr == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        s_if.TVALID = 1'b0; m_if.TREADY = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (prev_stall) begin
        check("stall_tdata_stable", 32'(m_if.TDATA), 32'(prev_td));
        check("stall_tlast_stable", 32'(m_if.TLAST), 32'(prev_tl));
      end
      if (res_valid) begin
        check("res_valid_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) check("res_data", 32'(res_data), 32'(expq.pop_front()));
      end
      if (done) begin
        dn_cnt++;
        fin = 1'b1;
      end
      if (!fin) begin
        sv = 1'b0;
        if (!ended && r_ptr < nres && (r_ptr != nres - 1 || m_ptr == total))
          sv = (rmode == 0) ? 1'b1 : ($urandom % 4 != 0);
        s_if.TVALID = sv;
        if (sv) begin
          s_if.TDATA = rdat[r_ptr]; s_if.TKEEP = rkeep[r_ptr]; s_if.TLAST = rlast[r_ptr];
          if (s_if.TREADY) begin
            if (rkeep[r_ptr] == 2'b11) begin expq.push_back(rdat[r_ptr]); exp_cnt++; end
            if (rlast[r_ptr]) begin
              if (m_ptr < total) exp_err = 1'b1;
              else ended = 1'b1;
            end
            r_ptr++;
          end
        end else begin
          s_if.TDATA = 16'($urandom); s_if.TKEEP = 2'($urandom); s_if.TLAST = 1'($urandom);
        end
        ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[cyc % 4] : 1'($urandom % 2);
        m_if.TREADY = ready;
        if (m_if.TVALID && ready) begin
          if (m_ptr < total) begin
            check("m_tdata", 32'(m_if.TDATA), 32'(eb[m_ptr]));
            check("m_tlast", 32'(m_if.TLAST), 32'(el[m_ptr]));
          end else begin
            check("m_beat_count", 32'(m_ptr + 1), 32'(total));
          end
          m_ptr++;
        end
        prev_stall = m_if.TVALID && !ready;
        prev_td = m_if.TDATA; prev_tl = m_if.TLAST;
      end else begin
        s_if.TVALID = 1'b0; m_if.TREADY = 1'b0;
      end
      @(negedge clk);
    end

    if (exp_cnt != fl + dl - 1) exp_err = 1'b1;
    check("done_count", 32'(dn_cnt), 32'd1);
    check("done_pulse_low", 32'(done), 32'd0);
    check("res_count", res_count, 32'(exp_cnt));
    check("err_len", 32'(err_len), 32'(exp_err));
    check("idle_after_frame", 32'(busy), 32'd0);
    check("master_beats", 32'(m_ptr), 32'(total));
    check("results_all_seen", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 10'd0; wr_data = 16'd0;
    filt_len = 9'd3; data_len = 16'd4; start = 1'b0;
    m_if.TREADY = 1'b0;
    s_if.TVALID = 1'b0; s_if.TDATA = 16'd0; s_if.TKEEP = 2'b00; s_if.TLAST = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // happy path: taps 1,2,3 over samples 1,1,1,1 -> 6 results
    load_small();
    run_frame(3, 4, 6, -1, 0, 1'b0, 0, 1'b0);
    // backpressure 1,0,0,1 plus start/write attempts while busy
    run_frame(3, 4, 6, -1, 1, 1'b0, 0, 1'b1);
    // the busy-time write to tap 0 must not have landed
    run_frame(3, 4, 6, -1, 0, 1'b0, 0, 1'b0);
    // length error: TLAST on 4th result
    run_frame(3, 4, 4, -1, 0, 1'b0, 0, 1'b0);
    // early TLAST during DATA, proper TLAST later
    run_frame(3, 4, 6, 1, 0, 1'b0, 0, 1'b0);

    // config errors
    cfg_err(0, 4);
    cfg_err(3, DD + 1);
    cfg_err(FD + 1, 4);
    cfg_err(3, 0);

    // max filter; an out-of-range tap write must not alias onto tap 44
    load_rand(FD, 1);
    wr(1'b0, 300, 16'hBEEF);
    wr_idle();
    run_frame(FD, 1, FD, -1, 2, 1'b0, 0, 1'b0);

    // max data length
    load_rand(1, DD);
    run_frame(1, DD, DD, -1, 0, 1'b0, 0, 1'b0);

    // randomized frames with partial-keep beats and varying result counts
    for (int t = 0; t < 3; t++) begin
      int fl, dl, nr;
      fl = $urandom_range(1, 40);
      dl = $urandom_range(1, 200);
      nr = fl + dl - 2 + $urandom_range(0, 2);
      if (nr < 1) nr = 1;
      load_rand(fl, dl);
      run_frame(fl, dl, nr, -1, 2, 1'b1, 0, 1'b0);
    end

    // reset after 2 data beats, then replay from beat 0
    load_small();
    run_frame(3, 4, 6, -1, 0, 1'b0, 5, 1'b0);
    load_small();
    run_frame(3, 4, 6, -1, 0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
